// File: rtl/gpr_pkg.sv
// Shared constants, write-kind encoding and bus-slice helpers for the GPR file.
package gpr_pkg;

  localparam int unsigned GPR_DATA_W  = 32;
  localparam int unsigned GPR_ADDR_W  = 5;
  localparam int unsigned REG_ZERO    = 0;
  localparam int unsigned GPR_OVF_REG = 30;
  localparam int unsigned GPR_OVF_BIT = 0;

  typedef enum logic [1:0] {
    WR_NONE,
    WR_NORMAL,
    WR_OVF
  } wr_kind_e;

  function automatic int unsigned addr_lo(input int unsigned port, input int unsigned addr_w);
    return port * addr_w;
  endfunction

  function automatic int unsigned data_lo(input int unsigned port, input int unsigned data_w);
    return port * data_w;
  endfunction

endpackage

// File: rtl/gpr_scoreboard.sv
// Per-register pending bits: set at issue, cleared at writeback, set wins on a tie.
module gpr_scoreboard
  import gpr_pkg::*;
#(
  parameter int unsigned ADDR_W = GPR_ADDR_W,
  parameter int unsigned NUM_RD = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clr_en,
  input  logic [ADDR_W-1:0]        clr_addr,
  input  logic                     set_en,
  input  logic [ADDR_W-1:0]        set_addr,
  input  logic [NUM_RD*ADDR_W-1:0] look_addr,
  output logic [NUM_RD-1:0]        look_pend
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [DEPTH-1:0] pend;
  logic [DEPTH-1:0] pend_next;

  always_comb begin
    pend_next = pend;
    if (clr_en) pend_next[clr_addr] = 1'b0;
    if (set_en) pend_next[set_addr] = 1'b1;
    pend_next[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) pend <= '0;
    else       pend <= pend_next;
  end

  for (genvar g = 0; g < NUM_RD; g++) begin : g_look
    assign look_pend[g] = pend[look_addr[addr_lo(g, ADDR_W) +: ADDR_W]];
  end

endmodule

// File: rtl/gpr_file_sb.sv
// General-purpose register file with overflow-trap write rule and RAW scoreboard.
// Optional same-cycle write forwarding when GPR_BYPASS_EN is defined.
module gpr_file_sb
  import gpr_pkg::*;
#(
  parameter int unsigned DATA_W  = GPR_DATA_W,
  parameter int unsigned ADDR_W  = GPR_ADDR_W,
  parameter int unsigned NUM_RD  = 2,
  parameter int unsigned OVF_REG = GPR_OVF_REG,
  parameter int unsigned OVF_BIT = GPR_OVF_BIT
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     overflow,
  input  logic                     sb_set,
  input  logic [ADDR_W-1:0]        sb_addr,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_pos,
  output logic [NUM_RD-1:0]        rd_pend
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs [DEPTH];
  wr_kind_e          wr_kind;
  logic [NUM_RD-1:0] sb_pend;

  always_comb begin
    wr_kind = WR_NONE;
    if (wr_en) begin
      if (overflow)                        wr_kind = WR_OVF;
      else if (wr_addr != ADDR_W'(REG_ZERO)) wr_kind = WR_NORMAL;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else begin
      unique case (wr_kind)
        WR_NORMAL: regs[wr_addr] <= wr_data;
        WR_OVF:    regs[OVF_REG][OVF_BIT] <= 1'b1;
        default:   ;
      endcase
    end
  end

  gpr_scoreboard #(
    .ADDR_W (ADDR_W),
    .NUM_RD (NUM_RD)
  ) u_sb (
    .clk       (clk),
    .reset     (reset),
    .clr_en    (wr_en),
    .clr_addr  (wr_addr),
    .set_en    (sb_set),
    .set_addr  (sb_addr),
    .look_addr (rd_addr),
    .look_pend (sb_pend)
  );

  for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] stored;
    logic [DATA_W-1:0] data;
    logic              pend;

    assign ra     = rd_addr[addr_lo(g, ADDR_W) +: ADDR_W];
    assign stored = (ra == ADDR_W'(REG_ZERO)) ? '0 : regs[ra];

`ifdef GPR_BYPASS_EN
    // Forwarded pending reflects the post-edge scoreboard: retire clears, a same-cycle issue re-sets.
    always_comb begin
      data = stored;
      pend = sb_pend[g];
      if (wr_kind == WR_NORMAL && wr_addr == ra) begin
        data = wr_data;
        pend = sb_set && (sb_addr == ra);
      end else if (wr_kind == WR_OVF && ra == ADDR_W'(OVF_REG) && ra != ADDR_W'(REG_ZERO)) begin
        data[OVF_BIT] = 1'b1;
      end
    end
`else
    assign data = stored;
    assign pend = sb_pend[g];
`endif

    assign rd_data[data_lo(g, DATA_W) +: DATA_W] = data;
    assign rd_pos[g]  = !data[DATA_W-1] && (data != '0);
    assign rd_pend[g] = pend;
  end

endmodule

// File: tb/tb_gpr_file_sb.sv
// Self-checking bench for gpr_file_sb (NUM_RD=4): vector table plus reset/bypass sequences.
module tb_gpr_file_sb;

`ifdef GPR_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        overflow;
  logic        sb_set;
  logic [4:0]  sb_addr;
  logic [19:0] rd_addr;
  logic [127:0] rd_data;
  logic [3:0]  rd_pos;
  logic [3:0]  rd_pend;

  gpr_file_sb #(
    .DATA_W  (32),
    .ADDR_W  (5),
    .NUM_RD  (4),
    .OVF_REG (30),
    .OVF_BIT (0)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .overflow (overflow),
    .sb_set   (sb_set),
    .sb_addr  (sb_addr),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_pos   (rd_pos),
    .rd_pend  (rd_pend)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        ovf;
    logic        ss;
    logic [4:0]  sa;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic [31:0] d0;
    logic        pos0;
    logic        pend0;
    logic [31:0] d1;
    logic        pos1;
    logic        pend1;
  } vec_t;

  vec_t tbl [18];
  vec_t exp_q [$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_port(input string name, input int p, input logic [31:0] d,
                            input logic pos, input logic pend);
    check($sformatf("%s p%0d data", name, p), rd_data[p*32 +: 32], d);
    check($sformatf("%s p%0d pos", name, p), {31'b0, rd_pos[p]}, {31'b0, pos});
    check($sformatf("%s p%0d pend", name, p), {31'b0, rd_pend[p]}, {31'b0, pend});
  endtask

  task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic ovf, input logic ss, input logic [4:0] sa,
                       input logic [4:0] r0, input logic [4:0] r1,
                       input logic [4:0] r2, input logic [4:0] r3);
    wr_en    = we;
    wr_addr  = wa;
    wr_data  = wd;
    overflow = ovf;
    sb_set   = ss;
    sb_addr  = sa;
    rd_addr  = {r3, r2, r1, r0};
  endtask

  task automatic next_cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    // we wa wd ovf ss sa | ra0 ra1 | d0 pos0 pend0 | d1 pos1 pend1
    tbl[0]  = '{0, 0,  32'h0,        0, 0, 0, 5,  30, 32'h0,        0, 0, 32'h0,        0, 0};
    tbl[1]  = '{1, 5,  32'h1234,     0, 0, 0, 7,  30, 32'h0,        0, 0, 32'h0,        0, 0};
    tbl[2]  = '{1, 0,  32'hFFFFFFFF, 0, 1, 7, 5,  0,  32'h1234,     1, 0, 32'h0,        0, 0};
    tbl[3]  = '{1, 7,  32'h55,       1, 1, 9, 0,  7,  32'h0,        0, 0, 32'h0,        0, 1};
    tbl[4]  = '{0, 0,  32'h0,        0, 0, 0, 7,  30, 32'h0,        0, 0, 32'h1,        1, 0};
    tbl[5]  = '{0, 0,  32'h0,        0, 0, 0, 9,  7,  32'h0,        0, 1, 32'h0,        0, 0};
    tbl[6]  = '{1, 9,  32'hA,        0, 1, 9, 30, 5,  32'h1,        1, 0, 32'h1234,     1, 0};
    tbl[7]  = '{0, 0,  32'h0,        0, 0, 0, 9,  30, 32'hA,        1, 1, 32'h1,        1, 0};
    tbl[8]  = '{1, 9,  32'hB,        0, 0, 0, 5,  7,  32'h1234,     1, 0, 32'h0,        0, 0};
    tbl[9]  = '{0, 0,  32'h0,        0, 0, 0, 9,  30, 32'hB,        1, 0, 32'h1,        1, 0};
    tbl[10] = '{1, 30, 32'h10,       0, 0, 0, 9,  5,  32'hB,        1, 0, 32'h1234,     1, 0};
    tbl[11] = '{1, 12, 32'h7FFFFFFF, 0, 1, 0, 30, 0,  32'h10,       1, 0, 32'h0,        0, 0};
    tbl[12] = '{1, 13, 32'hFFFFFFFF, 0, 0, 0, 0,  12, 32'h0,        0, 0, 32'h7FFFFFFF, 1, 0};
    tbl[13] = '{1, 3,  32'h99,       1, 0, 0, 13, 12, 32'hFFFFFFFF, 0, 0, 32'h7FFFFFFF, 1, 0};
    tbl[14] = '{0, 0,  32'h0,        0, 1, 9, 30, 3,  32'h11,       1, 0, 32'h0,        0, 0};
    tbl[15] = '{0, 0,  32'h0,        0, 1, 9, 9,  13, 32'hB,        1, 1, 32'hFFFFFFFF, 0, 0};
    tbl[16] = '{1, 9,  32'hC,        0, 0, 0, 30, 12, 32'h11,       1, 0, 32'h7FFFFFFF, 1, 0};
    tbl[17] = '{0, 0,  32'h0,        0, 0, 0, 9,  12, 32'hC,        1, 0, 32'h7FFFFFFF, 1, 0};

    drive(0, 0, 0, 0, 0, 0, 5, 9, 30, 12);
    reset = 1'b1;
    #1;
    for (int p = 0; p < 4; p++) check_port("in_reset", p, 32'h0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    for (int r = 0; r < 18; r++) begin
      vec_t e;
      drive(tbl[r].we, tbl[r].wa, tbl[r].wd, tbl[r].ovf, tbl[r].ss, tbl[r].sa,
            tbl[r].ra0, tbl[r].ra1, tbl[r].ra0, tbl[r].ra1);
      exp_q.push_back(tbl[r]);
      #1;
      e = exp_q.pop_front();
      for (int p = 0; p < 4; p++) begin
        if (p % 2 == 0) check_port($sformatf("row%0d", r), p, e.d0, e.pos0, e.pend0);
        else            check_port($sformatf("row%0d", r), p, e.d1, e.pos1, e.pend1);
      end
      next_cycle();
    end

    // Mid-run asynchronous reset with live data and a pending bit.
    drive(0, 0, 0, 0, 1, 9, 9, 5, 30, 12);
    next_cycle();
    drive(0, 0, 0, 0, 0, 0, 9, 5, 30, 12);
    #1;
    check_port("pre_reset", 0, 32'hC, 1'b1, 1'b1);
    check_port("pre_reset", 1, 32'h1234, 1'b1, 1'b0);
    reset = 1'b1;
    #1;
    for (int p = 0; p < 4; p++) check_port("mid_reset", p, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b0;

    // Same-cycle write of a negative value to r3 (r3 = 0 after reset).
    drive(1, 3, 32'h8000_0000, 0, 0, 0, 3, 30, 3, 30);
    #1;
    check_port("byp_wr", 0, BYP ? 32'h8000_0000 : 32'h0, 1'b0, 1'b0);
    next_cycle();
    drive(0, 0, 0, 0, 0, 0, 3, 30, 3, 30);
    #1;
    check_port("byp_after", 0, 32'h8000_0000, 1'b0, 1'b0);

    // Overflow forwarding into the status register.
    drive(1, 4, 32'h77, 1, 0, 0, 30, 4, 30, 4);
    #1;
    check_port("byp_ovf", 0, BYP ? 32'h1 : 32'h0, BYP, 1'b0);
    next_cycle();
    drive(0, 0, 0, 0, 0, 0, 30, 4, 30, 4);
    #1;
    check_port("ovf_after", 0, 32'h1, 1'b1, 1'b0);
    check_port("ovf_after", 1, 32'h0, 1'b0, 1'b0);

    // Write r12 with a same-cycle issue to r12, all four ports reading it.
    drive(1, 12, 32'h7FFF_FFFF, 0, 1, 12, 12, 12, 12, 12);
    #1;
    for (int p = 0; p < 4; p++)
      check_port("byp_r12", p, BYP ? 32'h7FFF_FFFF : 32'h0, BYP, BYP);
    next_cycle();
    drive(0, 0, 0, 0, 0, 0, 12, 12, 12, 12);
    #1;
    for (int p = 0; p < 4; p++) check_port("all_r12", p, 32'h7FFF_FFFF, 1'b1, 1'b1);
    next_cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
